// File: rtl/tinyalu_master_pkg.sv
// tinyalu_master_pkg: shared states, opcodes, command kinds and defaults for tinyalu_master
package tinyalu_master_pkg;
  typedef enum logic [2:0] {IDLE, ALU_RUN, BUS_WR, BUS_RD, RD_WAIT, RSP} state_e;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic KIND_ALU = 1'b0;
  localparam logic KIND_BUS = 1'b1;
  localparam int DEF_TIMEOUT = 16;
  function automatic logic is_alu_op(input logic [2:0] op);
    return op inside {OP_ADD, OP_AND, OP_XOR, OP_MUL};
  endfunction
endpackage

// File: rtl/tinyalu_master_tmo.sv
// tinyalu_master_tmo: ALU_RUN cycle counter raising expire_o on the TIMEOUT-th cycle
// Ports: clk, reset_n (sync, active-low), clr_i (restart count), en_i (in ALU_RUN),
//        expire_o (high during the TIMEOUT-th enabled cycle since clear).
module tinyalu_master_tmo
  import tinyalu_master_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 8'd1;
  end
  assign expire_o = en_i && (cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/tinyalu_master.sv
// tinyalu_master: command sequencer driving a tinyalu and a simple register bus
// Ports: cmd_* command handshake in, rsp_* response handshake out, A/B/op/start/done/result
//        to the ALU, bus_* to the bus slave, busy when not IDLE.
// Optional: define TINYALU_MASTER_TIMEOUT_EN to abort ALU operations after TIMEOUT cycles.
module tinyalu_master
  import tinyalu_master_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_kind,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_bus_wr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  op,
  output logic        start,
  input  logic        done,
  input  logic [15:0] result,
  output logic        bus_valid,
  output logic        bus_op,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wr_data,
  input  logic [15:0] bus_rd_data,
  output logic        busy
);
  state_e state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic rsp_err_q, rsp_err_d;
`ifdef TINYALU_MASTER_TIMEOUT_EN
  logic tmo_clr, tmo_expire;
  tinyalu_master_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .reset_n(reset_n),
    .clr_i(tmo_clr),
    .en_i(state_q == ALU_RUN),
    .expire_o(tmo_expire)
  );
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
`ifdef TINYALU_MASTER_TIMEOUT_EN
    tmo_clr = 1'b0;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        a_d = cmd_a;
        b_d = cmd_b;
        op_d = cmd_op;
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        rsp_data_d = '0;
        rsp_err_d = (cmd_kind == KIND_ALU) && !is_alu_op(cmd_op) && (cmd_op != OP_NOP);
        if (cmd_kind == KIND_BUS) state_d = cmd_bus_wr ? BUS_WR : BUS_RD;
        else state_d = is_alu_op(cmd_op) ? ALU_RUN : RSP;
`ifdef TINYALU_MASTER_TIMEOUT_EN
        tmo_clr = 1'b1;
`endif
      end
      ALU_RUN: if (done) begin
        rsp_data_d = result;
        rsp_err_d = 1'b0;
        state_d = RSP;
      end
`ifdef TINYALU_MASTER_TIMEOUT_EN
      else if (tmo_expire) begin
        rsp_data_d = '0;
        rsp_err_d = 1'b1;
        state_d = RSP;
      end
`endif
      BUS_WR: state_d = RSP;
      BUS_RD: state_d = RD_WAIT;
      RD_WAIT: begin
        rsp_data_d = bus_rd_data;
        state_d = RSP;
      end
      RSP: state_d = rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign start = state_q == ALU_RUN;
  assign A = a_q;
  assign B = b_q;
  assign op = op_q;
  assign bus_valid = (state_q == BUS_WR) || (state_q == BUS_RD);
  assign bus_op = state_q == BUS_WR;
  assign bus_addr = addr_q;
  assign bus_wr_data = wdata_q;
  assign rsp_valid = state_q == RSP;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_tinyalu_master.sv
// tb_tinyalu_master: directed bench for tinyalu_master with an ALU model and a bus slave
module tb_tinyalu_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_kind = 1'b0, cmd_bus_wr = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [15:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_data;
  logic [7:0] A, B;
  logic [2:0] op;
  logic start, done = 1'b0;
  logic [15:0] result = '0;
  logic bus_valid, bus_op, busy;
  logic [15:0] bus_addr, bus_wr_data, bus_rd_data = '0;
  int checks = 0, passes = 0;
  bit alu_dead = 1'b0;
  int acnt = 0;
  logic [7:0] last_a = '0;
  logic [15:0] mem [16];

  tinyalu_master #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_bus_wr(cmd_bus_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .A(A), .B(B), .op(op), .start(start), .done(done), .result(result),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    done <= 1'b0;
    if (!start) acnt <= 0;
    else if (!done && !alu_dead) begin
      last_a <= A;
      if (acnt == ((op == 3'd4) ? 2 : 0)) begin
        done <= 1'b1;
        acnt <= 0;
        result <= (op == 3'd1) ? 16'(A) + 16'(B) : (op == 3'd2) ? {8'h00, A & B} :
                  (op == 3'd3) ? {8'h00, A ^ B} : 16'(A) * 16'(B);
      end else acnt <= acnt + 1;
    end
  end

  always @(posedge clk) begin
    if (bus_valid && bus_op) mem[bus_addr[3:0]] <= bus_wr_data;
    if (bus_valid && !bus_op) bus_rd_data <= (bus_addr == 16'h0009) ? {8'h00, last_a} : mem[bus_addr[3:0]];
  end

  task automatic send(input logic k, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic w, input logic [15:0] ad, input logic [15:0] wd);
    cmd_kind = k; cmd_op = o; cmd_a = a; cmd_b = b; cmd_bus_wr = w; cmd_addr = ad; cmd_wdata = wd;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int sc, output int bv, output bit moved);
    logic [18:0] abo;
    bit got;
    lat = 1; sc = 0; bv = 0; moved = 1'b0; got = 1'b0; abo = '0;
    while (!rsp_valid && lat < 200) begin
      if (start) begin
        if (got && {A, B, op} !== abo) moved = 1'b1;
        abo = {A, B, op};
        got = 1'b1;
        sc++;
      end
      if (bus_valid) bv++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid, rsp_err, start, bus_valid, bus_op} !== 6'b100000)
      $display("FAIL reset_ctrl got %b want 100000", {cmd_ready, rsp_valid, rsp_err, start, bus_valid, bus_op}); else passes++;
    checks++; if ({rsp_data, A, B, op, bus_addr, bus_wr_data, busy} !== '0)
      $display("FAIL reset_data got %h want 0", {rsp_data, A, B, op, bus_addr, bus_wr_data, busy}); else passes++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_add();
    int lat, sc, bv; bit mv;
    send(1'b0, 3'd1, 8'h05, 8'h03, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    checks++; if (lat !== 3) $display("FAIL add_lat got %0d want 3", lat); else passes++;
    checks++; if (sc !== 2) $display("FAIL add_start_cycles got %0d want 2", sc); else passes++;
    checks++; if (rsp_data !== 16'h0008) $display("FAIL add_data got %h want 0008", rsp_data); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL add_err got %b want 0", rsp_err); else passes++;
    checks++; if (start !== 1'b0) $display("FAIL add_start_low got %b want 0", start); else passes++;
    ack();
    checks++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) $display("FAIL add_return got %b want 100", {cmd_ready, rsp_valid, busy}); else passes++;
  endtask

  task automatic test_alu_mul();
    int lat, sc, bv; bit mv;
    send(1'b0, 3'd4, 8'hFF, 8'hFF, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    checks++; if (sc !== 4) $display("FAIL mul_start_cycles got %0d want 4", sc); else passes++;
    checks++; if (mv !== 1'b0) $display("FAIL mul_abo_stable got %b want 0", mv); else passes++;
    checks++; if (lat !== 5) $display("FAIL mul_lat got %0d want 5", lat); else passes++;
    checks++; if ({rsp_data, rsp_err} !== {16'hFE01, 1'b0}) $display("FAIL mul_data got %h/%b want fe01/0", rsp_data, rsp_err); else passes++;
    ack();
  endtask

  task automatic test_bus();
    int lat, sc, bv; bit mv;
    send(1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0008, 16'h0001);
    wait_rsp(lat, sc, bv, mv);
    checks++; if (lat !== 2) $display("FAIL wr_lat got %0d want 2", lat); else passes++;
    checks++; if (bv !== 1) $display("FAIL wr_bus_cycles got %0d want 1", bv); else passes++;
    checks++; if ({rsp_data, rsp_err} !== 17'h0) $display("FAIL wr_rsp got %h/%b want 0000/0", rsp_data, rsp_err); else passes++;
    ack();
    send(1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0008, 16'h0000);
    wait_rsp(lat, sc, bv, mv);
    checks++; if (lat !== 3) $display("FAIL rd_lat got %0d want 3", lat); else passes++;
    checks++; if (bv !== 1) $display("FAIL rd_bus_cycles got %0d want 1", bv); else passes++;
    checks++; if ({rsp_data, rsp_err} !== {16'h0001, 1'b0}) $display("FAIL rd8_data got %h/%b want 0001/0", rsp_data, rsp_err); else passes++;
    ack();
    send(1'b0, 3'd1, 8'hFF, 8'h01, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    checks++; if (rsp_data !== 16'h0100) $display("FAIL add_ff_data got %h want 0100", rsp_data); else passes++;
    ack();
    send(1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0009, 16'h0000);
    wait_rsp(lat, sc, bv, mv);
    checks++; if (rsp_data[0] !== 1'b1) $display("FAIL rd9_bit0 got %b want 1", rsp_data[0]); else passes++;
    checks++; if (rsp_data !== 16'h00FF) $display("FAIL rd9_data got %h want 00ff", rsp_data); else passes++;
    ack();
  endtask

  task automatic test_nop_illegal();
    int lat, sc, bv; bit mv;
    send(1'b0, 3'd0, 8'h12, 8'h34, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    checks++; if ({lat, sc} !== {32'd1, 32'd0}) $display("FAIL nop_lat_start got %0d/%0d want 1/0", lat, sc); else passes++;
    checks++; if ({rsp_data, rsp_err} !== 17'h0) $display("FAIL nop_rsp got %h/%b want 0000/0", rsp_data, rsp_err); else passes++;
    ack();
    send(1'b0, 3'd6, 8'h12, 8'h34, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    checks++; if ({lat, sc} !== {32'd1, 32'd0}) $display("FAIL ill_lat_start got %0d/%0d want 1/0", lat, sc); else passes++;
    checks++; if ({rsp_data, rsp_err} !== {16'h0000, 1'b1}) $display("FAIL ill_rsp got %h/%b want 0000/1", rsp_data, rsp_err); else passes++;
    ack();
  endtask

  task automatic test_stall();
    int lat, sc, bv; bit mv;
    send(1'b0, 3'd3, 8'hF0, 8'h3C, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, cmd_ready, rsp_data} !== {1'b1, 1'b0, 16'h00CC})
        $display("FAIL stall_hold cycle %0d got %b/%b/%h want 1/0/00cc", i, rsp_valid, cmd_ready, rsp_data); else passes++;
      @(negedge clk);
    end
    ack();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL stall_release got %b want 1", cmd_ready); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, sc, bv; bit mv;
    send(1'b0, 3'd2, 8'hF0, 8'h3C, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    checks++; if ({lat, rsp_data} !== {32'd3, 16'h0030}) $display("FAIL b2b_and got %0d/%h want 3/0030", lat, rsp_data); else passes++;
    ack();
    send(1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0003, 16'hABCD);
    wait_rsp(lat, sc, bv, mv);
    ack();
    send(1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0003, 16'h0000);
    wait_rsp(lat, sc, bv, mv);
    checks++; if ({lat, rsp_data} !== {32'd3, 16'hABCD}) $display("FAIL b2b_rd got %0d/%h want 3/abcd", lat, rsp_data); else passes++;
    ack();
  endtask

  task automatic test_timeout();
    int lat, sc, bv; bit mv;
    alu_dead = 1'b1;
    send(1'b0, 3'd1, 8'h01, 8'h01, 1'b0, 16'h0, 16'h0);
`ifdef TINYALU_MASTER_TIMEOUT_EN
    wait_rsp(lat, sc, bv, mv);
    checks++; if ({lat, sc} !== {32'd17, 32'd16}) $display("FAIL tmo_lat_start got %0d/%0d want 17/16", lat, sc); else passes++;
    checks++; if ({rsp_data, rsp_err} !== {16'h0000, 1'b1}) $display("FAIL tmo_rsp got %h/%b want 0000/1", rsp_data, rsp_err); else passes++;
    ack();
`else
    repeat (40) @(negedge clk);
    checks++; if ({rsp_valid, start, busy} !== 3'b011) $display("FAIL wait_forever got %b want 011", {rsp_valid, start, busy}); else passes++;
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if ({start, cmd_ready} !== 2'b01) $display("FAIL wait_reset got %b want 01", {start, cmd_ready}); else passes++;
    reset_n = 1'b1;
    @(negedge clk);
`endif
    alu_dead = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat, sc, bv; bit mv;
    send(1'b0, 3'd4, 8'hFF, 8'hFF, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (start !== 1'b1) $display("FAIL mid_running got %b want 1", start); else passes++;
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if ({start, bus_valid, rsp_valid, cmd_ready, busy} !== 5'b00010)
      $display("FAIL mid_reset got %b want 00010", {start, bus_valid, rsp_valid, cmd_ready, busy}); else passes++;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || start) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) $display("FAIL mid_no_rsp got %0d want 0", seen); else passes++;
    send(1'b0, 3'd1, 8'h01, 8'h02, 1'b0, 16'h0, 16'h0);
    wait_rsp(lat, sc, bv, mv);
    checks++; if (rsp_data !== 16'h0003) $display("FAIL mid_recover got %h want 0003", rsp_data); else passes++;
    ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_add();
    test_alu_mul();
    test_bus();
    test_nop_illegal();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tinyalu_master.md
TINYALU_MASTER -- requirements
Module: tinyalu_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum cycles to wait for done per ALU operation (range 2..255).
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have command ports cmd_valid in 1, cmd_ready out 1, cmd_kind in 1 (0=ALU, 1=bus), cmd_op in 3, cmd_a in 8, cmd_b in 8, cmd_bus_wr in 1, cmd_addr in 16, cmd_wdata in 16.
REQ-005 SHALL have response ports rsp_valid out 1, rsp_ready in 1, rsp_data out 16, rsp_err out 1.
REQ-006 SHALL have ALU-side ports A out 8, B out 8, op out 3, start out 1, done in 1, result in 16.
REQ-007 SHALL have bus-side ports bus_valid out 1, bus_op out 1 (1=write), bus_addr out 16, bus_wr_data out 16, bus_rd_data in 16.
REQ-008 SHALL have port busy out 1, high whenever state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ALU_RUN, BUS_WR, BUS_RD, RD_WAIT, RSP.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid && cmd_ready and all fields are registered.
REQ-011 SHALL, for cmd_kind=0 with op 1..4 (add/and/xor/mul), enter ALU_RUN, drive A/B/op from the registered command, and hold start=1 with A/B/op stable until done=1 is sampled.
REQ-012 SHALL, in the cycle done=1 is sampled in ALU_RUN, capture result into rsp_data, clear rsp_err, enter RSP and drive start=0 from the next cycle.
REQ-013 SHALL, for cmd_kind=0 with op=0 (no-op), skip ALU activity (start never asserted) and enter RSP with rsp_data=0, rsp_err=0.
REQ-014 SHALL, for cmd_kind=0 with op 5..7, skip ALU activity and enter RSP with rsp_data=0, rsp_err=1.
REQ-015 SHALL, for cmd_kind=1 with cmd_bus_wr=1, enter BUS_WR for exactly one cycle driving bus_valid=1, bus_op=1, bus_addr, bus_wr_data, then RSP with rsp_data=0, rsp_err=0.
REQ-016 SHALL, for cmd_kind=1 with cmd_bus_wr=0, drive bus_valid=1, bus_op=0, bus_addr for one cycle in BUS_RD, go to RD_WAIT, capture bus_rd_data at the end of RD_WAIT (read data is registered in the slave, one cycle latency), then RSP.
REQ-017 SHALL drive bus_valid=0 in every state other than BUS_WR and BUS_RD.
REQ-018 SHALL hold rsp_valid=1 with rsp_data/rsp_err stable in RSP until rsp_ready=1; on rsp_valid && rsp_ready return to IDLE (cmd_ready=1 next cycle).
REQ-019 SHALL ignore done when not in ALU_RUN and ignore bus_rd_data outside RD_WAIT.
REQ-020 SHALL give minimum latencies (accept to rsp_valid): bus write 2 cycles, bus read 3 cycles, no-op/illegal 1 cycle, ALU = cycles to done + 1.

Reset
REQ-021 SHALL on reset_n=0 at a clock edge enter IDLE and set cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, start=0, A=0, B=0, op=0, bus_valid=0, bus_op=0, bus_addr=0, bus_wr_data=0, busy=0.
REQ-022 SHALL abandon any in-flight operation on reset (including mid ALU_RUN), with start low from the first cycle after the reset edge; no response is produced for the aborted command.

Configuration
REQ-023 SHALL, with TINYALU_MASTER_TIMEOUT_EN defined, count cycles in ALU_RUN and, if done is not seen within TIMEOUT cycles, drop start, enter RSP with rsp_data=0, rsp_err=1.
REQ-024 SHALL, without TINYALU_MASTER_TIMEOUT_EN, wait in ALU_RUN indefinitely for done; no counter logic is present.

Structure
REQ-025 SHALL place the state enum, ALU opcode constants (NOP=0, ADD=1, AND=2, XOR=3, MUL=4), cmd_kind constants and default TIMEOUT in package tinyalu_master_pkg.
REQ-026 SHALL implement the timeout counter as sub-module tinyalu_master_tmo (clear on ALU_RUN entry, expire flag), instantiated only under TINYALU_MASTER_TIMEOUT_EN.

Verification
REQ-027 SHALL cover ALU add A=0x05 B=0x03 against tinyalu -> rsp_data=0x0008, rsp_err=0, start low cycle after done.
REQ-028 SHALL cover ALU mul A=0xFF B=0xFF -> start held through 3-cycle multiply, rsp_data=0xFE01.
REQ-029 SHALL cover bus write addr 0x0008 data 0x0001 then read addr 0x0008 -> rsp_data=0x0001; read addr 0x0009 after add with A=0xFF -> rsp_data bit0=1.
REQ-030 SHALL cover rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0 throughout.
REQ-031 SHALL cover done tied low with TIMEOUT=16 and macro defined -> rsp_err=1, rsp_data=0 after 16 ALU_RUN cycles; op=6 -> rsp_err=1, start never asserted.
REQ-032 SHALL cover reset_n=0 during ALU_RUN mul -> start=0, bus_valid=0, rsp_valid=0, cmd_ready=1 after reset edge.
